// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and its consumer.
// The consumer drives the pixel enable; everything else flows from the generator.
interface vga_timing_gen_if #(
    parameter int CNT_W   = 10,
    parameter int FRAME_W = 8
);
    logic               en;
    logic               hsync;
    logic               vsync;
    logic               active;
    logic [CNT_W-1:0]   x;
    logic [CNT_W-1:0]   y;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;
    logic               hsync_d;
    logic               vsync_d;
    logic               active_d;

    modport master (
        input  en,
        output hsync, vsync, active, x, y,
        output line_start, frame_start, frame_cnt,
        output hsync_d, vsync_d, active_d
    );

    modport slave (
        output en,
        input  hsync, vsync, active, x, y,
        input  line_start, frame_start, frame_cnt,
        input  hsync_d, vsync_d, active_d
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// A (hc, vc) position counter advances on every enabled dclk edge; the
// registered outputs describe the position that was current at that edge.
// A per-signal delay line keeps sync/blanking aligned with a pipelined renderer.
module vga_timing_gen #(
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 29,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int CNT_W      = 10,
    parameter int PIPE_DELAY = 2,
    parameter int FRAME_W    = 8
) (
    input  logic             dclk,
    input  logic             clr_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA0     = H_SYNC + H_BP;
    localparam int VA0     = V_SYNC + V_BP;
    // One extra bit so the end-of-region bounds may equal 2^CNT_W.
    localparam int CW1     = CNT_W + 1;

    localparam logic [CW1-1:0]   HS_END  = CW1'(H_SYNC);
    localparam logic [CW1-1:0]   VS_END  = CW1'(V_SYNC);
    localparam logic [CW1-1:0]   HA_BEG  = CW1'(HA0);
    localparam logic [CW1-1:0]   HA_END  = CW1'(HA0 + H_ACTIVE);
    localparam logic [CW1-1:0]   VA_BEG  = CW1'(VA0);
    localparam logic [CW1-1:0]   VA_END  = CW1'(VA0 + V_ACTIVE);
    localparam logic [CNT_W-1:0] HA0_N   = CNT_W'(HA0);
    localparam logic [CNT_W-1:0] VA0_N   = CNT_W'(VA0);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic             HS_ON   = 1'(HS_POL);
    localparam logic             VS_ON   = 1'(VS_POL);

    // Raster position
    logic [CNT_W-1:0]   hc_reg;
    logic [CNT_W-1:0]   vc_reg;
    logic               hc_last;
    logic               vc_last;

    // Decode of the current position
    logic               hsync_next;
    logic               vsync_next;
    logic               active_next;
    logic [CNT_W-1:0]   x_next;
    logic [CNT_W-1:0]   y_next;
    logic               line_start_next;
    logic               frame_start_next;

    // Registered outputs
    logic               hsync_reg;
    logic               vsync_reg;
    logic               active_reg;
    logic [CNT_W-1:0]   x_reg;
    logic [CNT_W-1:0]   y_reg;
    logic               line_start_reg;
    logic               frame_start_reg;
    logic [FRAME_W-1:0] frame_cnt_reg;
    // Set on the edge that leaves the last position of a frame, so the
    // counter bumps together with the following frame_start.
    logic               wrap_pend_reg;

    assign hc_last = (hc_reg == H_LAST);
    assign vc_last = (vc_reg == V_LAST);

    // Position counter: hc runs every enabled edge, vc steps when hc wraps.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hc_reg <= '0;
            vc_reg <= '0;
        end else if (vga.en) begin
            if (hc_last) begin
                hc_reg <= '0;
                vc_reg <= vc_last ? '0 : vc_reg + CNT_W'(1);
            end else begin
                hc_reg <= hc_reg + CNT_W'(1);
            end
        end
    end

    // Combinational decode of (hc, vc) into sync, blanking, coordinates and strobes.
    always_comb begin
        logic [CW1-1:0] hc_ext;
        logic [CW1-1:0] vc_ext;
        logic           h_in;
        logic           v_in;
        hc_ext           = {1'b0, hc_reg};
        vc_ext           = {1'b0, vc_reg};
        h_in             = (hc_ext >= HA_BEG) && (hc_ext < HA_END);
        v_in             = (vc_ext >= VA_BEG) && (vc_ext < VA_END);
        hsync_next       = (hc_ext < HS_END) ? HS_ON : ~HS_ON;
        vsync_next       = (vc_ext < VS_END) ? VS_ON : ~VS_ON;
        active_next      = h_in && v_in;
        x_next           = active_next ? (hc_reg - HA0_N) : '0;
        y_next           = active_next ? (vc_reg - VA0_N) : '0;
        line_start_next  = (hc_reg == '0);
        frame_start_next = (hc_reg == '0) && (vc_reg == '0);
    end

    // Output registers: load the decode on enabled edges; strobes drop whenever en is low.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hsync_reg       <= ~HS_ON;
            vsync_reg       <= ~VS_ON;
            active_reg      <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else if (vga.en) begin
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            active_reg      <= active_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
        end else begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end
    end

    // Completed-frame counter, bumped on the edge that presents the next frame's (0,0).
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            wrap_pend_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else if (vga.en) begin
            wrap_pend_reg <= hc_last && vc_last;
            if (wrap_pend_reg) begin
                frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
            end
        end
    end

    assign vga.hsync       = hsync_reg;
    assign vga.vsync       = vsync_reg;
    assign vga.active      = active_reg;
    assign vga.x           = x_reg;
    assign vga.y           = y_reg;
    assign vga.line_start  = line_start_reg;
    assign vga.frame_start = frame_start_reg;
    assign vga.frame_cnt   = frame_cnt_reg;

    // Delay line: each stage captures the previous one on enabled edges.
    generate
        if (PIPE_DELAY == 0) begin : g_nodelay
            assign vga.hsync_d  = hsync_reg;
            assign vga.vsync_d  = vsync_reg;
            assign vga.active_d = active_reg;
        end else begin : g_delay
            for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
                logic hs_in;
                logic vs_in;
                logic act_in;
                logic hs_q;
                logic vs_q;
                logic act_q;

                if (gi == 0) begin : g_src_out
                    assign hs_in  = hsync_reg;
                    assign vs_in  = vsync_reg;
                    assign act_in = active_reg;
                end else begin : g_src_prev
                    assign hs_in  = g_stage[gi-1].hs_q;
                    assign vs_in  = g_stage[gi-1].vs_q;
                    assign act_in = g_stage[gi-1].act_q;
                end

                // One delay stage; reset parks it at the inactive levels.
                always_ff @(posedge dclk or negedge clr_n) begin
                    if (!clr_n) begin
                        hs_q  <= ~HS_ON;
                        vs_q  <= ~VS_ON;
                        act_q <= 1'b0;
                    end else if (vga.en) begin
                        hs_q  <= hs_in;
                        vs_q  <= vs_in;
                        act_q <= act_in;
                    end
                end
            end

            assign vga.hsync_d  = g_stage[PIPE_DELAY-1].hs_q;
            assign vga.vsync_d  = g_stage[PIPE_DELAY-1].vs_q;
            assign vga.active_d = g_stage[PIPE_DELAY-1].act_q;
        end
    endgenerate
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that succeeds the fixed 640x480 counter-and-sync logic in the display path. It produces sync pulses, an active-video flag, zero-based pixel coordinates, line and frame strobes, and a frame counter. It also provides a configurable delay line so that sync and blanking stay aligned with a pipelined pixel renderer. A pixel-enable input lets the block run from a clock faster than the pixel rate.

## Interface
Parameters:
- H_SYNC, 96: hsync pulse width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- H_ACTIVE, 640: active pixels per line
- H_FP, 16: horizontal front porch, in pixels
- V_SYNC, 2: vsync pulse width, in lines
- V_BP, 29: vertical back porch, in lines
- V_ACTIVE, 480: active lines per frame
- V_FP, 10: vertical front porch, in lines
- HS_POL, 0: asserted level of hsync (0 = active-low)
- VS_POL, 0: asserted level of vsync
- CNT_W, 10: width of counters and coordinates; must satisfy H_TOTAL, V_TOTAL ≤ 2^CNT_W
- PIPE_DELAY, 2: delay stages on the *_d outputs; legal range 0..8
- FRAME_W, 8: width of frame_cnt

Ports:
- dclk, in, 1: clock
- clr_n, in, 1: reset, asynchronous and active-low
- en, in, 1: pixel enable; the raster advances only on dclk edges where en=1
- hsync, out, 1: horizontal sync, asserted at level HS_POL
- vsync, out, 1: vertical sync, asserted at level VS_POL
- active, out, 1: high while the current position is in the active area
- x, out, CNT_W: active-area column, 0..H_ACTIVE-1; 0 when not active
- y, out, CNT_W: active-area row, 0..V_ACTIVE-1; 0 when not active
- line_start, out, 1: strobe at hc=0
- frame_start, out, 1: strobe at hc=0 and vc=0
- frame_cnt, out, FRAME_W: count of completed frames, modulo 2^FRAME_W
- hsync_d, vsync_d, active_d, out, 1 each: hsync, vsync and active delayed by PIPE_DELAY en-stages

## Operation
- Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800 at defaults); V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (521 at defaults).
- Internal position (hc, vc) resets to (0,0).
- On each dclk edge with en=1:
  - The outputs load the decode of the current (hc, vc).
  - hc advances. When hc=H_TOTAL-1 it wraps to 0 and vc advances.
  - vc wraps to 0 after V_TOTAL-1.
- Decode of (hc, vc):
  - hsync is asserted when hc < H_SYNC.
  - vsync is asserted when vc < V_SYNC.
  - Let HA0 = H_SYNC+H_BP and VA0 = V_SYNC+V_BP. active = (HA0 ≤ hc < HA0+H_ACTIVE) and (VA0 ≤ vc < VA0+V_ACTIVE).
  - x = hc-HA0 and y = vc-VA0 when active, otherwise 0.
  - line_start = (hc==0); frame_start = (hc==0 && vc==0).
- frame_cnt increments when the position wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0). It updates on the same edge as the frame_start output and wraps silently.
- Delay line: PIPE_DELAY registers per signal, shifting only on en=1 edges. With PIPE_DELAY=0, each *_d output equals its undelayed counterpart.
- Reset and mid-operation behaviour: clr_n low immediately forces the following values, regardless of en:
  - hsync=~HS_POL and vsync=~VS_POL
  - active, x, y, line_start, frame_start and frame_cnt = 0
  - every delay stage holds its inactive value
  - position = (0,0)

## Timing
- Latency:
  - Outputs describe the position they were loaded from, and reflect it from the en edge onward.
  - The first en edge after reset release presents position (0,0): hsync and vsync asserted, line_start=frame_start=1.
- en low: hc, vc, hsync, vsync, active, x, y, frame_cnt and the delay lines hold their values.
- Strobe width: line_start and frame_start are high for exactly one dclk cycle. They clear on any edge where en=0, and also on an en=1 edge whose position has hc≠0.
- Rates with en tied high: one line every H_TOTAL dclk cycles and one frame every H_TOTAL·V_TOTAL cycles (416800 at defaults). With en=1 every Nth cycle, both scale by N.
- No combinational path from inputs to outputs. All outputs are registers.
- clr_n deassertion is synchronised externally; the block only requires asynchronous assertion.

## Test plan
- Reset at defaults. Hold clr_n=0 with en toggling → hsync=1, vsync=1, active=0, x=y=0, frame_cnt=0, *_d inactive. Release clr_n and give one en edge → hsync=0, vsync=0, line_start=frame_start=1.
- Line timing at defaults with en=1:
  - hsync is low for 96 cycles, period 800.
  - active rises on the 145th output cycle of line 31 with x=0, and falls after x=639.
  - line_start occurs once per 800 cycles.
- Frame timing:
  - vsync is low for 1600 cycles.
  - frame_start occurs every 416800 cycles.
  - y spans 0..479.
  - After 3 frames, frame_cnt=3.
- en=1 every other cycle: all periods double and line_start stays one dclk wide. With PIPE_DELAY=2, hsync_d equals hsync two en-edges later.
- Small configuration, e.g. H=1/1/4/1, V=1/1/3/1, FRAME_W=2, HS_POL=VS_POL=1:
  - hsync is high for 1 cycle per 7.
  - frame_cnt wraps 3→0 after 4 frames.
- Reset asserted mid-line at hc=400 → outputs go to reset values within the same cycle. Output restarts at (0,0) after release.
